spart_driver: RTL and testbench
===============================

// Module: spart_driver
// PURPOSE
//  Bus-master counterpart of the SPART peripheral: drives iocs/iorw/ioaddr/databus.
//  After reset, programs the 16-bit baud divisor selected by br_cfg.
//  Then runs an echo loop: poll rda, read the received byte, wait for tbr, write the byte back.
//  Sits beside the SPART in the minilab top level and replaces a processor for bring-up.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency; divisor = CLK_FREQ_HZ/baud - 1
// PORTS
//  clk      in     1  system clock
//  rst_n    in     1  asynchronous, active-low reset
//  br_cfg   in     2  baud select: 00=4800 01=9600 10=19200 11=38400 (asynchronous, switches)
//  rda      in     1  SPART receive data available
//  tbr      in     1  SPART transmit buffer ready
//  iocs     out    1  chip select; one cycle per bus access
//  iorw     out    1  1=read, 0=write
//  ioaddr   out    2  00=TX/RX buffer, 01=status, 10=DB low, 11=DB high
//  databus  inout  8  driven by this block only when iocs && !iorw, else 'z
//  rx_byte  out    8  last byte read from the SPART
//  echo_cnt out    8  count of bytes echoed; wraps 255->0
// BEHAVIOUR
//  Reset values: iocs=0, iorw=1, ioaddr=00, databus='z, rx_byte=0, echo_cnt=0, state=CFG_LO.
//  br_cfg passes through a 2-flop synchronizer (br_sync). Divisor comes from a constant table.
//  At 50 MHz: 10415/0x28AF, 5207/0x1457, 2603/0x0A2B, 1301/0x0515.
//  All accesses are single-cycle: iocs is high for exactly the one cycle the state is entered.
//  Read data is sampled from databus on the clk edge that ends that cycle.
//  FSM states and transitions:
//   CFG_LO : iocs=1, iorw=0, ioaddr=10, databus=div[7:0]; always -> CFG_HI
//   CFG_HI : iocs=1, iorw=0, ioaddr=11, databus=div[15:8]; latch br_sync as cur_cfg; -> WAIT_RX
//   WAIT_RX: iocs=0. If br_sync!=cur_cfg -> CFG_LO (has priority over rda); elif rda -> RD_RX
//   RD_RX  : iocs=1, iorw=1, ioaddr=00; rx_byte<=databus; -> WAIT_TX
//   WAIT_TX: iocs=0; tbr -> WR_TX. br_cfg changes are ignored here; the byte is never dropped.
//   WR_TX  : iocs=1, iorw=0, ioaddr=00, databus=tx_data; echo_cnt++; -> WAIT_RX
//  tx_data = rx_byte, or its case-folded value (see CONFIGURATION).
//  rda/tbr are sampled directly; they are synchronous to clk.
//  Minimum echo turnaround is 4 cycles (WAIT_RX, RD_RX, WAIT_TX, WR_TX).
//  rda and tbr both high in WAIT_RX: read first, then write. One transaction in flight; no queuing.
//  Reset mid-operation: async return to reset values; the divisor is reprogrammed from scratch.
//  Illegal or unreached state encodings -> CFG_LO.
// CONFIGURATION
//  SPART_DRV_CASE_FOLD_EN defined: in WR_TX, a rx_byte in 8'h61..8'h7A is sent minus 8'h20.
//   All other byte values are sent unchanged.
//  Not defined: tx_data == rx_byte. No other behaviour differs.
// STRUCTURE
//  Package spart_pkg: ioaddr constants (IOA_BUF, IOA_STAT, IOA_DBLO, IOA_DBHI).
//   Also holds the drv_state_t enum and the function baud_div(cfg, clk_hz) -> logic [15:0].
//  The 2-flop synchronizer is the only natural sub-module: sync2 (parameter WIDTH=2).
//  Everything else is one FSM plus registers in spart_driver.
// TESTING
//  1. Reset, br_cfg=01: cycle 1 writes 8'h57 at ioaddr=10; cycle 2 writes 8'h14 at ioaddr=11;
//     then iocs stays low.
//  2. Model asserts rda with bus read data 8'h41: RD_RX read at ioaddr 00; then wait tbr=1.
//     Expected: write of 8'h41 at ioaddr 00, echo_cnt=1, rx_byte=8'h41.
//  3. br_cfg 01->11 while idle in WAIT_RX: within 4 cycles, writes 8'h15 (ioaddr 10)
//     then 8'h05 (ioaddr 11).
//  4. br_cfg change while in WAIT_TX with tbr=0: no config writes until the pending byte is
//     written; reconfiguration follows.
//  5. CASE_FOLD_EN: rx 8'h61 -> tx 8'h41; rx 8'h7B -> tx 8'h7B. Without macro: rx 8'h61 -> tx 8'h61.
//  6. 256 echoes -> echo_cnt wraps to 0. rst_n pulsed during WAIT_TX -> outputs at reset values,
//     then CFG_LO sequence restarts. databus is 'z whenever !(iocs && !iorw).

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART bus constants, driver state encoding and baud divisor helper.
package spart_pkg;

    localparam logic [1:0] IOA_BUF  = 2'b00;
    localparam logic [1:0] IOA_STAT = 2'b01;
    localparam logic [1:0] IOA_DBLO = 2'b10;
    localparam logic [1:0] IOA_DBHI = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        WAIT_RX,
        RD_RX,
        WAIT_TX,
        WR_TX
    } drv_state_t;

    // cfg selects 4800 << cfg baud
    function automatic logic [15:0] baud_div(input logic [1:0] cfg, input int unsigned clk_hz);
        int unsigned q;
        q = clk_hz / (32'd4800 << cfg) - 32'd1;
        return q[15:0];
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for slow asynchronous inputs such as switches.
module sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/spart_driver.sv
// spart_driver: SPART bus master that programs the baud divisor, then echoes received bytes.
// Optional macro SPART_DRV_CASE_FOLD_EN: echo lowercase ASCII as uppercase.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_br_cfg,
    input  logic       i_rda,
    input  logic       i_tbr,
    output logic       o_iocs,
    output logic       o_iorw,
    output logic [1:0] o_ioaddr,
    inout  wire  [7:0] io_databus,
    output logic [7:0] o_rx_byte,
    output logic [7:0] o_echo_cnt
);

    localparam logic [15:0] DIV_TBL [4] = '{
        baud_div(2'd0, CLK_FREQ_HZ),
        baud_div(2'd1, CLK_FREQ_HZ),
        baud_div(2'd2, CLK_FREQ_HZ),
        baud_div(2'd3, CLK_FREQ_HZ)
    };

    drv_state_t  r_state;
    drv_state_t  w_next;
    logic [1:0]  w_br_sync;
    logic [1:0]  r_cur_cfg;
    logic [1:0]  r_boot;
    logic        w_run;
    logic [7:0]  r_rx_byte;
    logic [7:0]  r_echo_cnt;
    logic [15:0] w_div;
    logic [7:0]  w_tx_data;
    logic [7:0]  w_wdata;
    logic        w_iocs;
    logic        w_iorw;
    logic [1:0]  w_ioaddr;

    sync2 #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_br_cfg),
        .o_q   (w_br_sync)
    );

    // Hold off the first access until the synchronizer carries the real switch setting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_boot <= 2'b00;
        else        r_boot <= {r_boot[0], 1'b1};
    end

    assign w_run = r_boot[1];
    assign w_div = DIV_TBL[w_br_sync];

`ifdef SPART_DRV_CASE_FOLD_EN
    assign w_tx_data = (r_rx_byte >= 8'h61 && r_rx_byte <= 8'h7A) ? r_rx_byte - 8'h20 : r_rx_byte;
`else
    assign w_tx_data = r_rx_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CFG_LO;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = CFG_LO;
        w_iocs   = 1'b0;
        w_iorw   = 1'b1;
        w_ioaddr = IOA_BUF;
        w_wdata  = 8'h00;
        if (w_run) begin
            case (r_state)
                CFG_LO: begin
                    w_iocs   = 1'b1;
                    w_iorw   = 1'b0;
                    w_ioaddr = IOA_DBLO;
                    w_wdata  = w_div[7:0];
                    w_next   = CFG_HI;
                end
                CFG_HI: begin
                    w_iocs   = 1'b1;
                    w_iorw   = 1'b0;
                    w_ioaddr = IOA_DBHI;
                    w_wdata  = w_div[15:8];
                    w_next   = WAIT_RX;
                end
                WAIT_RX: w_next = (w_br_sync != r_cur_cfg) ? CFG_LO : i_rda ? RD_RX : WAIT_RX;
                RD_RX: begin
                    w_iocs = 1'b1;
                    w_next = WAIT_TX;
                end
                WAIT_TX: w_next = i_tbr ? WR_TX : WAIT_TX;
                WR_TX: begin
                    w_iocs  = 1'b1;
                    w_iorw  = 1'b0;
                    w_wdata = w_tx_data;
                    w_next  = WAIT_RX;
                end
                default: w_next = CFG_LO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_cfg  <= 2'b00;
            r_rx_byte  <= 8'h00;
            r_echo_cnt <= 8'h00;
        end else begin
            if (r_state == CFG_HI) r_cur_cfg <= w_br_sync;
            if (r_state == RD_RX)  r_rx_byte <= io_databus;
            if (r_state == WR_TX)  r_echo_cnt <= r_echo_cnt + 8'd1;
        end
    end

    assign o_iocs     = w_iocs;
    assign o_iorw     = w_iorw;
    assign o_ioaddr   = w_ioaddr;
    assign io_databus = (w_iocs && !w_iorw) ? w_wdata : 8'hzz;
    assign o_rx_byte  = r_rx_byte;
    assign o_echo_cnt = r_echo_cnt;

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: bench acting as the SPART; checks every bus access against an expected-access queue.
module tb_spart_driver;

    typedef struct packed {
        logic       rw;
        logic [1:0] a;
        logic [7:0] d;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] rx_byte, echo_cnt;
    wire  [7:0] databus;

    acc_t       exp_q[$];
    logic [7:0] m_rx = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    logic [7:0] last_w [4];
    int         n_reads = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         echoes = 0;

`ifdef SPART_DRV_CASE_FOLD_EN
    localparam logic [7:0] TX_OF_61 = 8'h41;
`else
    localparam logic [7:0] TX_OF_61 = 8'h61;
`endif

    assign databus = (iocs && iorw) ? rd_data : 8'hzz;

    spart_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_br_cfg   (br_cfg),
        .i_rda      (rda),
        .i_tbr      (tbr),
        .o_iocs     (iocs),
        .o_iorw     (iorw),
        .o_ioaddr   (ioaddr),
        .io_databus (databus),
        .o_rx_byte  (rx_byte),
        .o_echo_cnt (echo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] fold(input logic [7:0] x);
`ifdef SPART_DRV_CASE_FOLD_EN
        return (x >= 8'h61 && x <= 8'h7A) ? x - 8'h20 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [15:0] div_of(input logic [1:0] cfg);
        return 16'(50_000_000 / (4800 * (1 << cfg)) - 1);
    endfunction

    task automatic push_cfg(input logic [1:0] cfg);
        logic [15:0] d;
        d = div_of(cfg);
        exp_q.push_back('{1'b0, 2'b10, d[7:0]});
        exp_q.push_back('{1'b0, 2'b11, d[15:8]});
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic start_read(input logic [7:0] x);
        int target;
        target = n_reads + 1;
        rd_data = x;
        rda = 1'b1;
        for (int i = 0; i < 60 && n_reads < target; i++) @(posedge clk);
        #1;
        rda = 1'b0;
        chk("read_seen", n_reads >= target, 1);
    endtask

    task automatic echo(input logic [7:0] x);
        exp_q.push_back('{1'b1, 2'b00, x});
        exp_q.push_back('{1'b0, 2'b00, fold(x)});
        start_read(x);
        wait_empty("echo_done");
        echoes++;
    endtask

    always @(negedge clk) begin
        acc_t e;
        logic got_rd, got_echo;
        got_rd = 1'b0;
        got_echo = 1'b0;
        chk("rx_byte", rx_byte, m_rx);
        chk("echo_cnt", echo_cnt, m_cnt);
        if (iocs) begin
            chk("access_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("acc_rw", iorw, e.rw);
                chk("acc_addr", ioaddr, e.a);
                if (!e.rw) begin
                    chk("acc_wdata", databus, e.d);
                    last_w[ioaddr] = databus;
                    got_echo = (e.a == 2'b00);
                end else begin
                    got_rd = 1'b1;
                end
            end
        end else begin
            chk("databus_z", databus === 8'hzz, 1);
        end
        if (got_rd) begin
            m_rx = e.d;
            n_reads++;
        end
        if (got_echo) m_cnt = m_cnt + 8'd1;
    end

    initial begin
        push_cfg(2'b01);
        #12;
        chk("rst_iocs", iocs, 0);
        chk("rst_iorw", iorw, 1);
        chk("rst_ioaddr", ioaddr, 0);
        chk("rst_databus_z", databus === 8'hzz, 1);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_echo_cnt", echo_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_empty("cfg_9600");
        chk("div_lo_9600", last_w[2], 8'h57);
        chk("div_hi_9600", last_w[3], 8'h14);
        repeat (10) @(posedge clk);
        #1;
        tbr = 1'b1;
        echo(8'h41);
        chk("echo1_rx", rx_byte, 8'h41);
        chk("echo1_cnt", echo_cnt, 1);
        chk("echo1_tx", last_w[0], 8'h41);
        echo(8'h61);
        chk("tx_of_61", last_w[0], TX_OF_61);
        echo(8'h7B);
        chk("tx_of_7b", last_w[0], 8'h7B);
        br_cfg = 2'b11;
        push_cfg(2'b11);
        repeat (4) @(posedge clk);
        #1;
        chk("reconfig_within_4", exp_q.size() <= 1, 1);
        wait_empty("cfg_38400");
        chk("div_lo_38400", last_w[2], 8'h15);
        chk("div_hi_38400", last_w[3], 8'h05);
        tbr = 1'b0;
        exp_q.push_back('{1'b1, 2'b00, 8'h5A});
        exp_q.push_back('{1'b0, 2'b00, fold(8'h5A)});
        start_read(8'h5A);
        br_cfg = 2'b10;
        push_cfg(2'b10);
        repeat (8) @(posedge clk);
        #1;
        chk("held_in_wait_tx", exp_q.size(), 3);
        tbr = 1'b1;
        wait_empty("tx_then_reconfig");
        echoes++;
        chk("div_lo_19200", last_w[2], 8'h2B);
        chk("div_hi_19200", last_w[3], 8'h0A);
        while (echoes < 256) echo(8'(echoes * 7 + 3));
        chk("echo_cnt_wrap", echo_cnt, 0);
        tbr = 1'b0;
        exp_q.push_back('{1'b1, 2'b00, 8'hC3});
        start_read(8'hC3);
        rst_n = 1'b0;
        m_rx = 8'h00;
        m_cnt = 8'h00;
        exp_q.delete();
        #1;
        chk("midrst_iocs", iocs, 0);
        chk("midrst_iorw", iorw, 1);
        chk("midrst_ioaddr", ioaddr, 0);
        chk("midrst_databus_z", databus === 8'hzz, 1);
        chk("midrst_rx_byte", rx_byte, 0);
        chk("midrst_echo_cnt", echo_cnt, 0);
        push_cfg(2'b10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tbr = 1'b1;
        wait_empty("cfg_after_reset");
        chk("div_lo_after_reset", last_w[2], 8'h2B);
        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
